// File: rtl/bn_cychain_cnt.sv
// Up/down counter built on a per-bit LUT+carry ripple chain.
// Load and saturate muxing sit in front of the flops; the chain only steps.

module bn_cychain_cell (
  input  logic q,
  input  logic ci,
  input  logic dn,
  output logic sum,
  output logic co
);
  logic prop;

  // LUT: toggle this bit when the carry (borrow) reaches it.
  assign sum  = q ^ ci;
  // Carry cell: ripple continues through ones going up, zeros going down.
  assign prop = dn ? ~q : q;
  assign co   = prop & ci;
endmodule

module bn_cychain_cnt #(
  parameter int          WIDTH = 8,
  parameter int          SAT   = 0,
  parameter logic [31:0] INIT  = 32'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ldval,
  input  logic             en,
  input  logic             dn,
  output logic [WIDTH-1:0] q,
  output logic             zf,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] INIT_W = INIT[WIDTH-1:0];

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] q_nxt;
  logic             limit;

  assign carry[0] = en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    bn_cychain_cell u_cell (
      .q   (q[i]),
      .ci  (carry[i]),
      .dn  (dn),
      .sum (sum[i]),
      .co  (carry[i+1])
    );
  end

  // Carry out of the top cell means the whole word was at the step limit.
  assign limit = carry[WIDTH];

  always_comb begin
    q_nxt = sum;
    if (ld)                      q_nxt = ldval;
    else if ((SAT != 0) && limit) q_nxt = q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q   <= INIT_W;
      zf  <= (INIT_W == '0);
      ovf <= 1'b0;
    end else begin
      q   <= q_nxt;
      zf  <= (q_nxt == '0);
      ovf <= ~ld & limit;
    end
  end
endmodule

// File: tb/tb_bn_cychain_cnt.sv
// Directed scenarios plus a randomized run over several widths/modes,
// each instance checked every cycle against an arithmetic reference model.

module tb_bn_cychain_cnt;
  localparam int N = 6;
  localparam int          WS [N] = '{4, 4, 4, 2, 16, 32};
  localparam bit          SS [N] = '{0, 1, 0, 0, 1, 0};
  localparam logic [31:0] IS [N] = '{0, 0, 3, 0, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n, ld, en, dn;
  logic [31:0] ldv;

  logic [3:0]  q0, q1, q2;
  logic [1:0]  q3;
  logic [15:0] q4;
  logic [31:0] q5;
  logic [N-1:0] zf_d, ovf_d;
  logic [31:0] dq [N];

  longint mq [N];
  bit     mz [N], mo [N];
  int     total = 0, bad = 0;

  always #5 clk = ~clk;

  bn_cychain_cnt #(.WIDTH(4),  .SAT(0), .INIT(32'd0)) u0 (.clk(clk), .rst_n(rst_n), .ld(ld), .ldval(ldv[3:0]),  .en(en), .dn(dn), .q(q0), .zf(zf_d[0]), .ovf(ovf_d[0]));
  bn_cychain_cnt #(.WIDTH(4),  .SAT(1), .INIT(32'd0)) u1 (.clk(clk), .rst_n(rst_n), .ld(ld), .ldval(ldv[3:0]),  .en(en), .dn(dn), .q(q1), .zf(zf_d[1]), .ovf(ovf_d[1]));
  bn_cychain_cnt #(.WIDTH(4),  .SAT(0), .INIT(32'd3)) u2 (.clk(clk), .rst_n(rst_n), .ld(ld), .ldval(ldv[3:0]),  .en(en), .dn(dn), .q(q2), .zf(zf_d[2]), .ovf(ovf_d[2]));
  bn_cychain_cnt #(.WIDTH(2),  .SAT(0), .INIT(32'd0)) u3 (.clk(clk), .rst_n(rst_n), .ld(ld), .ldval(ldv[1:0]),  .en(en), .dn(dn), .q(q3), .zf(zf_d[3]), .ovf(ovf_d[3]));
  bn_cychain_cnt #(.WIDTH(16), .SAT(1), .INIT(32'd0)) u4 (.clk(clk), .rst_n(rst_n), .ld(ld), .ldval(ldv[15:0]), .en(en), .dn(dn), .q(q4), .zf(zf_d[4]), .ovf(ovf_d[4]));
  bn_cychain_cnt #(.WIDTH(32), .SAT(0), .INIT(32'd0)) u5 (.clk(clk), .rst_n(rst_n), .ld(ld), .ldval(ldv),       .en(en), .dn(dn), .q(q5), .zf(zf_d[5]), .ovf(ovf_d[5]));

  always_comb begin
    dq[0] = 32'(q0); dq[1] = 32'(q1); dq[2] = 32'(q2);
    dq[3] = 32'(q3); dq[4] = 32'(q4); dq[5] = q5;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic with an explicit limit test.
  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      longint mask = (64'd1 << WS[k]) - 1;
      if (!rst_n) begin
        mq[k] = longint'(IS[k]) & mask; mo[k] = 0;
      end else if (ld) begin
        mq[k] = longint'(ldv) & mask; mo[k] = 0;
      end else if (en) begin
        if (!dn) begin
          mo[k] = (mq[k] == mask);
          if (!(mo[k] && SS[k])) mq[k] = (mq[k] + 1) & mask;
        end else begin
          mo[k] = (mq[k] == 0);
          if (!(mo[k] && SS[k])) mq[k] = (mq[k] - 1) & mask;
        end
      end else begin
        mo[k] = 0;
      end
      mz[k] = (mq[k] == 0);
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic [31:0] v,
                       input logic e, input logic d);
    rst_n = r; ld = l; ldv = v; en = e; dn = d;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("q[%0d]", k),   longint'(dq[k]),   mq[k]);
      chk($sformatf("zf[%0d]", k),  longint'(zf_d[k]), longint'(mz[k]));
      chk($sformatf("ovf[%0d]", k), longint'(ovf_d[k]), longint'(mo[k]));
    end
  endtask

  initial begin
    logic [3:0] expq [3];
    logic       expo [3];

    rst_n = 1'b0; ld = 1'b0; ldv = '0; en = 1'b0; dn = 1'b0;
    #2;
    cycle(0, 1, 32'h9, 1, 0);
    chk("rst_q0", longint'(q0), 0);   chk("rst_zf0", longint'(zf_d[0]), 1);
    chk("rst_ovf0", longint'(ovf_d[0]), 0);
    chk("rst_q2", longint'(q2), 3);   chk("rst_zf2", longint'(zf_d[2]), 0);

    // Wrap up
    cycle(1, 1, 32'hE, 0, 0);
    expq = '{4'hF, 4'h0, 4'h1}; expo = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0);
      chk("wrapup_q", longint'(q0), longint'(expq[i]));
      chk("wrapup_ovf", longint'(ovf_d[0]), longint'(expo[i]));
      chk("wrapup_zf", longint'(zf_d[0]), longint'(expq[i] == 0));
    end

    // Wrap down
    cycle(1, 1, 32'h1, 0, 0);
    expq = '{4'h0, 4'hF, 4'hE};
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 1);
      chk("wrapdn_q", longint'(q0), longint'(expq[i]));
      chk("wrapdn_ovf", longint'(ovf_d[0]), longint'(expq[i] == 4'hF));
    end

    // Saturate
    cycle(1, 1, 32'hF, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 1, 0);
      chk("sat_q", longint'(q1), 4'hF);
      chk("sat_ovf", longint'(ovf_d[1]), 1);
    end
    cycle(1, 0, 0, 1, 1);
    chk("sat_dn_q", longint'(q1), 4'hE);
    chk("sat_dn_ovf", longint'(ovf_d[1]), 0);

    // Load beats enable
    cycle(1, 1, 32'h5, 1, 1);
    chk("prio_q", longint'(q0), 5); chk("prio_ovf", longint'(ovf_d[0]), 0);
    cycle(1, 0, 32'h5, 1, 1);
    chk("prio_next_q", longint'(q0), 4);

    // Reset mid-count
    cycle(1, 1, 32'h0, 0, 0);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 1, 0);
    chk("mid_pre_q", longint'(q2), 7);
    cycle(0, 1, 32'hA, 1, 0);
    chk("mid_q", longint'(q2), 3); chk("mid_zf", longint'(zf_d[2]), 0);
    chk("mid_ovf", longint'(ovf_d[2]), 0);
    cycle(1, 0, 0, 0, 0);
    chk("mid_hold_q", longint'(q2), 3);
    cycle(1, 0, 0, 1, 0);
    chk("mid_resume_q", longint'(q2), 4);

    // Randomized sweep, loads biased toward the limits
    for (int n = 0; n < 10000; n++) begin
      logic [31:0] v;
      int sel = $urandom_range(0, 3);
      v = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF :
          (sel == 2) ? 32'hFFFF_FFFE : $urandom;
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0, v,
            $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
